// File: rtl/pic_pkg.sv
// Shared constants for the programmable interrupt controller core.
package pic_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned VEC_W   = 8;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned CTRL_W  = 3;

  // Register map
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_IMR      = 2'd1;
  localparam logic [1:0] ADDR_BASE_ISR = 2'd2;
  localparam logic [1:0] ADDR_CMD_IRR  = 2'd3;

  // Command opcodes carried in data_in[15:14]
  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_NS_EOI   = 2'b01;
  localparam logic [1:0] CMD_SP_EOI   = 2'b10;
  localparam logic [1:0] CMD_SET_PRIO = 2'b11;

  // Control register bit positions
  localparam int unsigned CTRL_LTIM   = 0;
  localparam int unsigned CTRL_ROTATE = 1;
  localparam int unsigned CTRL_AEOI   = 2;

  // Rank of an id under the rotating order; 0 is the highest priority.
  function automatic logic [4:0] prio_rank(input logic [ID_W-1:0] id,
                                           input logic [ID_W-1:0] lowest,
                                           input int unsigned     n);
    logic [5:0] r;
    r = 6'(id) + 6'(n) - 6'(lowest) - 6'd1;
    if (r >= 6'(n)) r = r - 6'(n);
    return 5'(r);
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: picks the first set bit after 'lowest'.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [ID_W-1:0]    lowest,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // Scan from the lowest priority up so the highest-priority hit is written last.
  always_comb begin
    int unsigned pos;
    found = 1'b0;
    id    = '0;
    pos   = 0;
    for (int unsigned k = NUM_IRQ; k > 0; k--) begin
      pos = 32'(lowest) + k;
      if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
      if (mask[IDX_W'(pos)]) begin
        found = 1'b1;
        id    = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/pic_param_core.sv
// Parameterised interrupt controller: IRR/ISR/IMR, rotating priority, EOI commands.
module pic_param_core
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ         = 8,
  parameter logic [7:0]  VECTOR_BASE_RST = 8'h08
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               chip_select,
  input  logic               write_enable,
  input  logic               read_enable,
  input  logic [1:0]         address,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               int_out,
  input  logic               inta,
  output logic [7:0]         vector,
  output logic               vector_valid
);

  logic [NUM_IRQ-1:0] irr, isr, imr, irq_prev;
  logic [CTRL_W-1:0]  ctrl;
  logic [VEC_W-1:0]   base;
  logic [ID_W-1:0]    lowest;

  logic [NUM_IRQ-1:0] irr_n, isr_n, ack_bit, eoi_bit, rise;
  logic [ID_W-1:0]    lowest_n;
  logic               int_out_n, vector_valid_n;
  logic [VEC_W-1:0]   vector_n;

  logic               pend_found, isr_found;
  logic [ID_W-1:0]    pend_id, isr_id;
  logic               int_req_c, ack, wr_en, id_ok;
  logic [1:0]         cmd;
  logic [ID_W-1:0]    cmd_id;
  logic               unused_data_bits;

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_pend_res (
    .mask   (irr & ~imr),
    .lowest (lowest),
    .found  (pend_found),
    .id     (pend_id)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
    .mask   (isr),
    .lowest (lowest),
    .found  (isr_found),
    .id     (isr_id)
  );

  assign unused_data_bits = ^data_in[13:8];

  // Request decision and command decode
  assign int_req_c = pend_found &&
                     (!isr_found ||
                      (prio_rank(pend_id, lowest, NUM_IRQ) < prio_rank(isr_id, lowest, NUM_IRQ)));
  assign ack    = inta && int_out && pend_found;
  assign wr_en  = chip_select && write_enable;
  assign cmd    = data_in[15:14];
  assign cmd_id = data_in[ID_W-1:0];
  assign id_ok  = (32'(cmd_id) < NUM_IRQ);

  // Next-state for request/service registers, priority pointer and vector output
  always_comb begin
    ack_bit        = ack ? (NUM_IRQ'(1) << pend_id) : '0;
    rise           = irq & ~irq_prev;
    eoi_bit        = '0;
    lowest_n       = lowest;
    vector_n       = vector;
    vector_valid_n = 1'b0;

    irr_n = ctrl[CTRL_LTIM] ? irq : ((irr & ~ack_bit) | rise);

    if (ack && ctrl[CTRL_AEOI] && ctrl[CTRL_ROTATE]) lowest_n = pend_id;

    if (wr_en && (address == ADDR_CMD_IRR)) begin
      case (cmd)
        CMD_NS_EOI: begin
          if (isr_found) begin
            eoi_bit = NUM_IRQ'(1) << isr_id;
            if (ctrl[CTRL_ROTATE]) lowest_n = isr_id;
          end
        end
        CMD_SP_EOI:   if (id_ok) eoi_bit = NUM_IRQ'(1) << cmd_id;
        CMD_SET_PRIO: if (id_ok) lowest_n = cmd_id;
        default: ;
      endcase
    end

    isr_n     = (isr & ~eoi_bit) | (ctrl[CTRL_AEOI] ? '0 : ack_bit);
    int_out_n = ack ? 1'b0 : int_req_c;

    if (ack) begin
      vector_n       = base + VEC_W'(pend_id);
      vector_valid_n = 1'b1;
    end else if (inta) begin
      vector_n       = base + VEC_W'(NUM_IRQ - 1);
      vector_valid_n = 1'b1;
    end
  end

  // State registers and programming-register writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irr          <= '0;
      isr          <= '0;
      imr          <= '1;
      irq_prev     <= '0;
      ctrl         <= '0;
      base         <= VECTOR_BASE_RST;
      lowest       <= ID_W'(NUM_IRQ - 1);
      int_out      <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
    end else begin
      irr          <= irr_n;
      isr          <= isr_n;
      irq_prev     <= irq;
      lowest       <= lowest_n;
      int_out      <= int_out_n;
      vector       <= vector_n;
      vector_valid <= vector_valid_n;
      if (wr_en) begin
        case (address)
          ADDR_CTRL:     ctrl <= data_in[CTRL_W-1:0];
          ADDR_IMR:      imr  <= data_in[NUM_IRQ-1:0];
          ADDR_BASE_ISR: base <= data_in[VEC_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Combinational register read-back, zero-extended
  always_comb begin
    data_out = '0;
    if (chip_select && read_enable) begin
      case (address)
        ADDR_CTRL:     data_out = DATA_W'(ctrl);
        ADDR_IMR:      data_out = DATA_W'(imr);
        ADDR_BASE_ISR: data_out = DATA_W'(isr);
        default:       data_out = DATA_W'(irr);
      endcase
    end
  end

endmodule

// File: tb/tb_pic_param_core.sv
// Directed self-checking bench for pic_param_core (8-line and 16-line instances).
module tb_pic_param_core;

  logic        clock;
  logic        reset_n;
  logic        chip_select, write_enable, read_enable;
  logic [1:0]  address;
  logic [15:0] data_in;
  logic        inta;
  logic [7:0]  irq8;
  logic [15:0] irq16;
  logic [15:0] data_out8, data_out16;
  logic        int_out8, int_out16;
  logic [7:0]  vector8, vector16;
  logic        vv8, vv16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rdata;

  pic_param_core #(.NUM_IRQ(8), .VECTOR_BASE_RST(8'h08)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select),
    .write_enable(write_enable), .read_enable(read_enable), .address(address),
    .data_in(data_in), .data_out(data_out8), .irq(irq8), .int_out(int_out8),
    .inta(inta), .vector(vector8), .vector_valid(vv8)
  );

  pic_param_core #(.NUM_IRQ(16), .VECTOR_BASE_RST(8'h08)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .chip_select(chip_select),
    .write_enable(write_enable), .read_enable(read_enable), .address(address),
    .data_in(data_in), .data_out(data_out16), .irq(irq16), .int_out(int_out16),
    .inta(inta), .vector(vector16), .vector_valid(vv16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    chip_select = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    tick();
    chip_select = 1'b0; write_enable = 1'b0; data_in = '0;
  endtask

  task automatic rd8(input logic [1:0] a, output logic [15:0] d);
    chip_select = 1'b1; read_enable = 1'b1; address = a;
    #1;
    d = data_out8;
    chip_select = 1'b0; read_enable = 1'b0;
  endtask

  task automatic rd16(input logic [1:0] a, output logic [15:0] d);
    chip_select = 1'b1; read_enable = 1'b1; address = a;
    #1;
    d = data_out16;
    chip_select = 1'b0; read_enable = 1'b0;
  endtask

  task automatic ack_cycle();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; chip_select = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    address = '0; data_in = '0; inta = 1'b0; irq8 = '0; irq16 = '0;
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    check_eq("rst int_out", 16'(int_out8), 16'h0000);
    check_eq("rst vector_valid", 16'(vv8), 16'h0000);
    check_eq("rst vector", 16'(vector8), 16'h0000);
    rd8(2'd1, rdata); check_eq("rst imr", rdata, 16'h00FF);
    rd8(2'd0, rdata); check_eq("rst ctrl", rdata, 16'h0000);
    reset_n = 1'b1;
    tick();

    // Edge on irq[3], acknowledge
    wr(2'd1, 16'h0000);
    irq8 = 8'h08;
    tick();
    rd8(2'd3, rdata); check_eq("edge irr", rdata, 16'h0008);
    check_eq("int_out before", 16'(int_out8), 16'h0000);
    tick();
    check_eq("int_out raised", 16'(int_out8), 16'h0001);
    ack_cycle();
    check_eq("ack3 vector", 16'(vector8), 16'h000B);
    check_eq("ack3 valid", 16'(vv8), 16'h0001);
    check_eq("ack3 int_out", 16'(int_out8), 16'h0000);
    rd8(2'd2, rdata); check_eq("ack3 isr", rdata, 16'h0008);
    rd8(2'd3, rdata); check_eq("ack3 irr", rdata, 16'h0000);
    tick();
    check_eq("valid one cycle", 16'(vv8), 16'h0000);

    // Lower priority blocked, higher priority nests
    irq8 = 8'h28;
    tick(); tick();
    check_eq("irq5 blocked", 16'(int_out8), 16'h0000);
    irq8 = 8'h2A;
    tick(); tick();
    check_eq("irq1 nests", 16'(int_out8), 16'h0001);
    ack_cycle();
    check_eq("ack1 vector", 16'(vector8), 16'h0009);
    rd8(2'd2, rdata); check_eq("nested isr", rdata, 16'h000A);
    wr(2'd3, 16'h4000);
    rd8(2'd2, rdata); check_eq("ns eoi isr", rdata, 16'h0008);
    rd8(2'd3, rdata); check_eq("masked pending irr", rdata, 16'h0020);
    wr(2'd3, 16'h800A);
    rd8(2'd2, rdata); check_eq("sp eoi bad id", rdata, 16'h0008);
    wr(2'd3, 16'h8003);
    rd8(2'd2, rdata); check_eq("sp eoi isr", rdata, 16'h0000);
    tick();
    check_eq("irq5 after eoi", 16'(int_out8), 16'h0001);
    wr(2'd1, 16'hFFFF);
    rd8(2'd1, rdata); check_eq("imr upper bits", rdata, 16'h00FF);
    chip_select = 1'b1; address = 2'd1;
    #1;
    check_eq("idle data_out", data_out8, 16'h0000);
    chip_select = 1'b0;

    // Rotation with set-priority and rotating EOI
    irq8 = '0;
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0002);
    wr(2'd3, 16'hC002);
    irq8 = 8'h0C;
    tick(); tick();
    check_eq("rot int_out", 16'(int_out8), 16'h0001);
    ack_cycle();
    check_eq("rot vector3", 16'(vector8), 16'h000B);
    wr(2'd3, 16'h4000);
    tick();
    check_eq("rot int_out2", 16'(int_out8), 16'h0001);
    ack_cycle();
    check_eq("rot vector2", 16'(vector8), 16'h000A);
    rd8(2'd2, rdata); check_eq("rot isr", rdata, 16'h0004);

    // Level mode with automatic EOI
    irq8 = '0;
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'h0005);
    irq8 = 8'h40;
    tick(); tick();
    check_eq("lvl int_out", 16'(int_out8), 16'h0001);
    ack_cycle();
    check_eq("lvl vector", 16'(vector8), 16'h000E);
    check_eq("lvl ack int_out", 16'(int_out8), 16'h0000);
    rd8(2'd2, rdata); check_eq("aeoi isr", rdata, 16'h0000);
    rd8(2'd3, rdata); check_eq("lvl irr", rdata, 16'h0040);
    tick();
    check_eq("lvl reassert", 16'(int_out8), 16'h0001);

    // Spurious acknowledge and mid-handshake reset
    irq8 = '0;
    do_reset();
    ack_cycle();
    check_eq("spurious vector", 16'(vector8), 16'h000F);
    check_eq("spurious valid", 16'(vv8), 16'h0001);
    rd8(2'd2, rdata); check_eq("spurious isr", rdata, 16'h0000);
    wr(2'd1, 16'h0000);
    irq8 = 8'h01;
    tick(); tick();
    check_eq("pre-reset int_out", 16'(int_out8), 16'h0001);
    reset_n = 1'b0;
    #1;
    check_eq("async rst int_out", 16'(int_out8), 16'h0000);
    rd8(2'd1, rdata); check_eq("async rst imr", rdata, 16'h00FF);
    check_eq("async rst valid", 16'(vv8), 16'h0000);
    reset_n = 1'b1;
    tick();

    // Sixteen-line instance with relocated base
    irq8 = '0; irq16 = '0;
    do_reset();
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0040);
    irq16 = 16'h1000;
    tick(); tick();
    check_eq("n16 int_out", 16'(int_out16), 16'h0001);
    rd16(2'd3, rdata); check_eq("n16 irr", rdata, 16'h1000);
    ack_cycle();
    check_eq("n16 vector", 16'(vector16), 16'h004C);
    check_eq("n16 valid", 16'(vv16), 16'h0001);
    check_eq("n8 spurious base40", 16'(vector8), 16'h0047);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
